ac_motor_ramp_ctrl: RTL and testbench

AC_MOTOR_RAMP_CTRL -- requirements
Module: ac_motor_ramp_ctrl

---
 rtl/ac_motor_ramp_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_ac_motor_ramp_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ac_motor_ramp_ctrl.sv
// AC motor ramp controller: soft-starts, soft-stops and reverses a
// sine-PWM drive by stepping frequency/amplitude words on carrier locks.
module ac_motor_ramp_ctrl #(
   parameter int FREQ_STEP = 1,
   parameter int AMP_STEP  = 16,
   parameter int PRESCALE  = 4,
   parameter int DIR_HOLD  = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        stop,
   input  logic        dir_cmd,
   input  logic [11:0] target_freq,
   input  logic [11:0] target_amp,
   input  logic        lock,
   output logic [11:0] frequency,
   output logic [11:0] amplitude,
   output logic        cw,
   output logic        ccw,
   output logic        enable,
   output logic        busy,
   output logic [2:0]  state
);

   localparam int LW = $clog2(PRESCALE + 1);
   localparam int HW = $clog2(DIR_HOLD + 1);
   localparam logic [11:0] FS = 12'(FREQ_STEP);
   localparam logic [11:0] AS = 12'(AMP_STEP);
   localparam logic [LW-1:0] LOCK_LAST = LW'(PRESCALE - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(DIR_HOLD - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RAMP = 3'd1,
      RUN  = 3'd2,
      DOWN = 3'd3,
      HOLD = 3'd4
   } state_t;

   state_t        state_q, state_nx;
   logic [11:0]   freq_q, freq_nx;
   logic [11:0]   amp_q, amp_nx;
   logic          dir_q, dir_nx;
   logic          stop_pend, stop_nx;
   logic [HW-1:0] hold_cnt, hold_nx;
   logic [LW-1:0] lock_cnt;
   logic          tick;
   logic          at_target;
   logic          at_zero;
   logic          abort;

   // Move cur toward tgt by at most step, never passing tgt.
   function automatic logic [11:0] toward(
      input logic [11:0] cur,
      input logic [11:0] tgt,
      input logic [11:0] step
   );
      logic [11:0] d;
      if (tgt > cur) begin
         d = tgt - cur;
         return cur + ((d > step) ? step : d);
      end
      d = cur - tgt;
      return cur - ((d > step) ? step : d);
   endfunction

   // Decrease cur by at most step, saturating at zero.
   function automatic logic [11:0] down_sat(
      input logic [11:0] cur,
      input logic [11:0] step
   );
      return (cur > step) ? cur - step : 12'd0;
   endfunction

   assign tick      = lock && (state_q != IDLE) && (lock_cnt == LOCK_LAST);
   assign at_target = (freq_q == target_freq) && (amp_q == target_amp);
   assign at_zero   = (freq_q == 12'd0) && (amp_q == 12'd0);
   assign abort     = stop || (dir_cmd != dir_q);

   // Lock prescaler: counts carrier locks, idles at zero when stopped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_cnt <= '0;
      end else if (state_q == IDLE) begin
         lock_cnt <= '0;
      end else if (lock) begin
         lock_cnt <= tick ? '0 : lock_cnt + 1'b1;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         freq_q    <= '0;
         amp_q     <= '0;
         dir_q     <= 1'b0;
         stop_pend <= 1'b0;
         hold_cnt  <= '0;
      end else begin
         state_q   <= state_nx;
         freq_q    <= freq_nx;
         amp_q     <= amp_nx;
         dir_q     <= dir_nx;
         stop_pend <= stop_nx;
         hold_cnt  <= hold_nx;
      end
   end

   // Next-state and ramp arithmetic.
   always_comb begin
      state_nx = state_q;
      freq_nx  = freq_q;
      amp_nx   = amp_q;
      dir_nx   = dir_q;
      stop_nx  = stop_pend;
      hold_nx  = hold_cnt;
      case (state_q)
         IDLE: begin
            stop_nx = 1'b0;
            hold_nx = '0;
            if (start && !stop && target_freq != 12'd0) begin
               state_nx = RAMP;
               dir_nx   = dir_cmd;
            end
         end
         RAMP: begin
            if (abort) begin
               state_nx = DOWN;
               stop_nx  = stop_pend | stop;
            end else begin
               if (tick) begin
                  freq_nx = toward(freq_q, target_freq, FS);
                  amp_nx  = toward(amp_q, target_amp, AS);
               end
               if (at_target) state_nx = RUN;
            end
         end
         RUN: begin
            if (abort) begin
               state_nx = DOWN;
               stop_nx  = stop_pend | stop;
            end else if (!at_target) begin
               state_nx = RAMP;
            end
         end
         DOWN: begin
            stop_nx = stop_pend | stop;
            if (at_zero) begin
               hold_nx = '0;
               if (stop_pend) begin
                  state_nx = IDLE;
                  stop_nx  = 1'b0;
               end else begin
                  state_nx = HOLD;
               end
            end else if (tick) begin
               freq_nx = down_sat(freq_q, FS);
               amp_nx  = down_sat(amp_q, AS);
            end
         end
         HOLD: begin
            if (stop) begin
               state_nx = IDLE;
               hold_nx  = '0;
            end else if (lock) begin
               if (hold_cnt == HOLD_LAST) begin
                  state_nx = RAMP;
                  dir_nx   = dir_cmd;
                  hold_nx  = '0;
               end else begin
                  hold_nx = hold_cnt + 1'b1;
               end
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign enable    = (state_q == RAMP) || (state_q == RUN) ||
                      (state_q == DOWN);
   assign cw        = enable & dir_q;
   assign ccw       = enable & ~dir_q;
   assign busy      = (state_q != IDLE);
   assign state     = state_q;
   assign frequency = freq_q;
   assign amplitude = amp_q;

endmodule

// File: tb/tb_ac_motor_ramp_ctrl.sv
// Directed bench for ac_motor_ramp_ctrl: start/stop ramps, reversal,
// amplitude clamping, async reset and stop-in-hold.
module tb_ac_motor_ramp_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        dir_cmd = 1'b0;
   logic [11:0] target_freq = '0;
   logic [11:0] target_amp = '0;
   logic        lock = 1'b0;
   logic [11:0] frequency;
   logic [11:0] amplitude;
   logic        cw;
   logic        ccw;
   logic        enable;
   logic        busy;
   logic [2:0]  state;

   int n_cmp = 0;
   int n_err = 0;

   ac_motor_ramp_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .stop        (stop),
      .dir_cmd     (dir_cmd),
      .target_freq (target_freq),
      .target_amp  (target_amp),
      .lock        (lock),
      .frequency   (frequency),
      .amplitude   (amplitude),
      .cw          (cw),
      .ccw         (ccw),
      .enable      (enable),
      .busy        (busy),
      .state       (state)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   // One lock pulse every 10 clocks.
   task automatic lock_pulse();
      repeat (9) step_clk();
      lock = 1'b1;
      step_clk();
      lock = 1'b0;
   endtask

   task automatic chk_outs(input string tag, input logic [2:0] st,
                           input logic [11:0] f, input logic [11:0] a,
                           input logic en, input logic c, input logic cc,
                           input logic b);
      chk({tag, ".state"}, 32'(state), 32'(st));
      chk({tag, ".freq"}, 32'(frequency), 32'(f));
      chk({tag, ".amp"}, 32'(amplitude), 32'(a));
      chk({tag, ".enable"}, 32'(enable), 32'(en));
      chk({tag, ".cw"}, 32'(cw), 32'(c));
      chk({tag, ".ccw"}, 32'(ccw), 32'(cc));
      chk({tag, ".busy"}, 32'(busy), 32'(b));
   endtask

   initial begin
      // Reset state
      repeat (3) step_clk();
      chk_outs("reset", 3'd0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Start cw ramp to 4/64
      rst_n = 1'b1;
      start = 1'b1;
      dir_cmd = 1'b1;
      target_freq = 12'd4;
      target_amp = 12'd64;
      step_clk();
      chk_outs("start", 3'd1, 12'd0, 12'd0, 1'b1, 1'b1, 1'b0, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         repeat (3) lock_pulse();
         chk("ramp_pre", 32'(frequency), 32'(i - 1));
         lock_pulse();
         chk("ramp_f", 32'(frequency), 32'(i));
         chk("ramp_a", 32'(amplitude), 32'(16 * i));
      end
      chk("ramp_last_state", 32'(state), 32'd1);
      step_clk();
      chk_outs("run", 3'd2, 12'd4, 12'd64, 1'b1, 1'b1, 1'b0, 1'b1);

      // Controlled stop
      stop = 1'b1;
      step_clk();
      chk("stop_down", 32'(state), 32'd3);
      for (int i = 1; i <= 4; i++) begin
         repeat (4) lock_pulse();
         chk("down_f", 32'(frequency), 32'(4 - i));
         chk("down_a", 32'(amplitude), 32'(64 - 16 * i));
      end
      step_clk();
      chk_outs("stopped", 3'd0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // start and stop together stay idle
      repeat (3) step_clk();
      chk("both_state", 32'(state), 32'd0);
      chk("both_en", 32'(enable), 32'd0);

      // Restart, then reverse direction
      stop = 1'b0;
      step_clk();
      chk("restart", 32'(state), 32'd1);
      repeat (16) lock_pulse();
      step_clk();
      chk_outs("run2", 3'd2, 12'd4, 12'd64, 1'b1, 1'b1, 1'b0, 1'b1);
      dir_cmd = 1'b0;
      step_clk();
      chk_outs("rev_down", 3'd3, 12'd4, 12'd64, 1'b1, 1'b1, 1'b0, 1'b1);
      repeat (16) lock_pulse();
      chk("rev_zero_f", 32'(frequency), 32'd0);
      chk("rev_zero_a", 32'(amplitude), 32'd0);
      step_clk();
      chk_outs("hold", 3'd4, 12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (7) lock_pulse();
      chk("hold7", 32'(state), 32'd4);
      lock_pulse();
      chk_outs("hold_exit", 3'd1, 12'd0, 12'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      repeat (16) lock_pulse();
      step_clk();
      chk_outs("run_ccw", 3'd2, 12'd4, 12'd64, 1'b1, 1'b0, 1'b1, 1'b1);

      // Amplitude clamps at 70 then ramps down to 30
      target_amp = 12'd70;
      step_clk();
      chk("a70_ramp", 32'(state), 32'd1);
      repeat (4) lock_pulse();
      chk("a70", 32'(amplitude), 32'd70);
      chk("a70_f", 32'(frequency), 32'd4);
      step_clk();
      chk("a70_run", 32'(state), 32'd2);
      target_amp = 12'd30;
      step_clk();
      chk("a30_ramp", 32'(state), 32'd1);
      repeat (4) lock_pulse();
      chk("a54", 32'(amplitude), 32'd54);
      repeat (4) lock_pulse();
      chk("a38", 32'(amplitude), 32'd38);
      repeat (4) lock_pulse();
      chk("a30", 32'(amplitude), 32'd30);
      step_clk();
      chk("a30_run", 32'(state), 32'd2);

      // Async reset mid-ramp
      target_amp = 12'd64;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      #1;
      chk("pre_ramp_idle", 32'(state), 32'd0);
      step_clk();
      chk("rst_ramp", 32'(state), 32'd1);
      repeat (8) lock_pulse();
      chk("mid_f", 32'(frequency), 32'd2);
      chk("mid_a", 32'(amplitude), 32'd32);
      rst_n = 1'b0;
      #1;
      chk_outs("async_rst", 3'd0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      #1;
      chk("rel_no_change", 32'(state), 32'd0);
      step_clk();
      chk_outs("rerun", 3'd1, 12'd0, 12'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      repeat (4) lock_pulse();
      chk("rerun_f", 32'(frequency), 32'd1);
      chk("rerun_a", 32'(amplitude), 32'd16);

      // Stop while holding
      dir_cmd = 1'b1;
      step_clk();
      chk("h_down", 32'(state), 32'd3);
      repeat (4) lock_pulse();
      step_clk();
      chk("h_hold", 32'(state), 32'd4);
      repeat (2) lock_pulse();
      stop = 1'b1;
      step_clk();
      chk_outs("hold_stop", 3'd0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
